// File: rtl/usbbootrom_arbiter.sv
// usbbootrom_arbiter: two-port read arbiter and sequencer for the USB boot ROM macro.
// Build option: define USBBOOTROM_ARB_FIXED_PRIO_EN for fixed port-0 priority (no round-robin pointer).
module usbbootrom_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_DEPTH  = 73728
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,
  output logic                  p0_rsp_err,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,
  output logic                  p1_rsp_err,
  output logic                  rom_me,
  output logic                  rom_oe,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  // state | meaning
  // IDLE  | no transaction; grant is combinational from req_valids
  // READ  | rom_me high with the latched address
  // DATA  | rom_oe high, rom_q captured into response register
  // RESP  | response presented to owner until its rsp_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(ROM_DEPTH);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  gnt0, gnt1, accept, in_range, idle, resp;
  logic [ADDR_WIDTH-1:0] sel_addr;

`ifdef USBBOOTROM_ARB_FIXED_PRIO_EN
  assign gnt1 = p1_req_valid && !p0_req_valid;
`else
  logic ptr_q, ptr_d;

  // A lone requester always wins; the pointer only breaks ties.
  assign gnt1 = p1_req_valid && (!p0_req_valid || ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = !gnt1;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign gnt0     = p0_req_valid && !gnt1;
  assign idle     = (state_q == IDLE);
  assign resp     = (state_q == RESP);
  assign accept   = idle && (gnt0 || gnt1);
  assign sel_addr = gnt1 ? p1_req_addr : p0_req_addr;
  assign in_range = ({1'b0, sel_addr} < DEPTH_LIMIT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt1;
          addr_d  = sel_addr;
          if (in_range) begin
            state_d = READ;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      READ: state_d = DATA;
      DATA: begin
        data_d  = rom_q;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? p1_rsp_ready : p0_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign p0_req_ready = idle && gnt0;
  assign p1_req_ready = idle && gnt1;

  assign p0_rsp_valid = resp && !owner_q;
  assign p1_rsp_valid = resp && owner_q;
  assign p0_rsp_data  = p0_rsp_valid ? data_q : '0;
  assign p1_rsp_data  = p1_rsp_valid ? data_q : '0;
  assign p0_rsp_err   = p0_rsp_valid && err_q;
  assign p1_rsp_err   = p1_rsp_valid && err_q;

  assign rom_me      = (state_q == READ);
  assign rom_oe      = (state_q == DATA);
  assign rom_address = addr_q;

endmodule

// File: tb/tb_usbbootrom_arbiter.sv
// Testbench for usbbootrom_arbiter: ROM model, vector table of transactions and a response scoreboard.
module tb_usbbootrom_arbiter;

  localparam logic [17:0] DEPTH = 18'd73728;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic [16:0] p0_req_addr = '0, p1_req_addr = '0;
  logic        p0_rsp_ready = 1'b0, p1_rsp_ready = 1'b0;
  logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_data, p1_rsp_data;
  logic        p0_rsp_err, p1_rsp_err;
  logic        rom_me, rom_oe;
  logic [16:0] rom_address;
  logic [31:0] rom_q;
  logic [31:0] rom_reg = 32'h0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        v0;
    logic [16:0] a0;
    logic        v1;
    logic [16:0] a1;
    int          w;
  } vec_t;
  vec_t vecs[10];

  usbbootrom_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(p0_rsp_data),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(p1_rsp_data),
    .p1_rsp_err(p1_rsp_err),
    .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address), .rom_q(rom_q)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [16:0] a);
    if (a == 17'h10) return 32'hDEADBEEF;
    return 32'(a) * 32'h9E3779B9 + 32'h1;
  endfunction

  // One-cycle registered ROM; q only meaningful while oe is high.
  always @(posedge clock) if (rom_me) rom_reg <= rom_word(rom_address);
  assign rom_q = rom_oe ? rom_reg : 32'hBAD0BAD0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic take_rsp(input int port);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got response on port %0d expected none", port);
      return;
    end
    e = sb.pop_front();
    chk32("rsp_port", 32'(port), 32'(e.port));
    chk32("rsp_data", port == 1 ? p1_rsp_data : p0_rsp_data, e.data);
    chk1("rsp_err", port == 1 ? p1_rsp_err : p0_rsp_err, e.err);
  endtask

  // Drive one request set at a negedge in IDLE and follow it through to the response.
  task automatic issue(input logic v0, input logic [16:0] a0, input logic v1,
                       input logic [16:0] a1, input int w);
    logic [16:0] a;
    logic        err;
    exp_t        e;
    a   = (w == 1) ? a1 : a0;
    err = ({1'b0, a} >= DEPTH);
    p0_req_valid = v0; p0_req_addr = a0;
    p1_req_valid = v1; p1_req_addr = a1;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    #1;
    chk1("p0_req_ready", p0_req_ready, w == 0);
    chk1("p1_req_ready", p1_req_ready, w == 1);
    e.port = w; e.data = err ? 32'h0 : rom_word(a); e.err = err;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    chk1("busy_no_ready", p0_req_ready | p1_req_ready, 1'b0);
    if (!err) begin
      chk1("rom_me_n1", rom_me, 1'b1);
      chk32("rom_addr_n1", 32'(rom_address), 32'(a));
      chk1("rsp_early", p0_rsp_valid | p1_rsp_valid, 1'b0);
      @(negedge clock);
      chk1("rom_oe_n2", rom_oe, 1'b1);
      chk1("rom_me_n2", rom_me, 1'b0);
      @(negedge clock);
    end else begin
      chk1("err_no_me", rom_me | rom_oe, 1'b0);
    end
    chk1("rsp_valid_owner", w == 1 ? p1_rsp_valid : p0_rsp_valid, 1'b1);
    chk1("rsp_valid_other", w == 1 ? p0_rsp_valid : p1_rsp_valid, 1'b0);
    take_rsp(w);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 17'h00010, 1'b0, 17'h00000, 0};
    vecs[1] = '{1'b1, 17'h00005, 1'b1, 17'h00006, 1};
    vecs[2] = '{1'b1, 17'h00005, 1'b1, 17'h00006, 0};
    vecs[3] = '{1'b1, 17'h00005, 1'b1, 17'h00006, 1};
    vecs[4] = '{1'b0, 17'h00000, 1'b1, 17'h12000, 1};
    vecs[5] = '{1'b0, 17'h00000, 1'b1, 17'h11FFF, 1};
    vecs[6] = '{1'b1, 17'h00005, 1'b1, 17'h00006, 0};
    vecs[7] = '{1'b1, 17'h1FFFF, 1'b0, 17'h00000, 0};
    vecs[8] = '{1'b1, 17'h00007, 1'b1, 17'h00008, 1};
    vecs[9] = '{1'b1, 17'h00000, 1'b0, 17'h00000, 0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk1("rst_req_ready", p0_req_ready | p1_req_ready, 1'b0);
    chk1("rst_rsp_valid", p0_rsp_valid | p1_rsp_valid, 1'b0);
    chk32("rst_rsp_data", p0_rsp_data | p1_rsp_data, 32'h0);
    chk1("rst_rsp_err", p0_rsp_err | p1_rsp_err, 1'b0);
    chk1("rst_rom_me_oe", rom_me | rom_oe, 1'b0);
    chk32("rst_rom_addr", 32'(rom_address), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      int w;
      w = vecs[i].w;
`ifdef USBBOOTROM_ARB_FIXED_PRIO_EN
      if (vecs[i].v0 && vecs[i].v1) w = 0;
`endif
      issue(vecs[i].v0, vecs[i].a0, vecs[i].v1, vecs[i].a1, w);
    end

    // Backpressure: p0 response stalled 5 cycles while p1 waits.
    begin
      exp_t e;
      p0_req_valid = 1'b1; p0_req_addr = 17'h00020;
      p1_req_valid = 1'b0;
      p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b1;
      #1;
      chk1("bp_accept", p0_req_ready, 1'b1);
      e.port = 0; e.data = rom_word(17'h00020); e.err = 1'b0;
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b1; p1_req_addr = 17'h00030;
      @(negedge clock);
      @(negedge clock);
      for (int k = 0; k < 5; k++) begin
        chk1("bp_rsp_valid", p0_rsp_valid, 1'b1);
        chk32("bp_rsp_data", p0_rsp_data, rom_word(17'h00020));
        chk1("bp_p1_ready", p1_req_ready, 1'b0);
        chk1("bp_p1_rsp_valid", p1_rsp_valid, 1'b0);
        if (k < 4) @(negedge clock);
      end
      p0_rsp_ready = 1'b1;
      take_rsp(0);
      @(negedge clock);
      issue(1'b0, 17'h0, 1'b1, 17'h00030, 1);
    end

    // Reset while in DATA: response discarded, pointer back to port 0.
    p0_req_valid = 1'b1; p0_req_addr = 17'h00040;
    p1_req_valid = 1'b0;
    #1;
    chk1("rd_accept", p0_req_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    p0_req_valid = 1'b0;
    @(negedge clock);
    chk1("rd_in_data", rom_oe, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk1("rd_oe_cleared", rom_oe | rom_me, 1'b0);
    chk32("rd_addr_cleared", 32'(rom_address), 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk1("rd_no_rsp", p0_rsp_valid | p1_rsp_valid, 1'b0);
      @(negedge clock);
    end
    issue(1'b1, 17'h00050, 1'b1, 17'h00051, 0);
    issue(1'b0, 17'h0, 1'b1, 17'h00060, 1);

    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    @(negedge clock);
    chk32("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
